// File: rtl/seg7_bcd_scan_pkg.sv
// Shared segment patterns and conversion FSM states for the BCD display scanner.
package seg7_bcd_scan_pkg;

    typedef logic [15:0] bcd_word_t;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_REQ   = 2'd1,
        C_WAIT  = 2'd2,
        C_LATCH = 2'd3
    } conv_state_e;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_bcd_scan_if.sv
// Start/done handshake and result word between the binary-to-BCD converter and its consumer.
interface seg7_bcd_scan_if;
    logic                          bcd_start;
    logic                          bcd_done;
    seg7_bcd_scan_pkg::bcd_word_t  bcd_din;

    modport master (output bcd_start, input bcd_done, input bcd_din);
    modport slave  (input bcd_start, output bcd_done, output bcd_din);
endinterface

// File: rtl/seg7_decode.sv
// Nibble to active-low 7-segment pattern; 10-15 render as a dash.
// Latency: combinational.
// Backpressure: none.
module seg7_decode
    import seg7_bcd_scan_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        if (blank_i) begin
            seg_o = SEG_OFF;
        end else begin
            case (nib_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg7_bcd_scan.sv
// Periodically requests a BCD conversion, latches the result and scans it onto a 4-digit display.
// Latency: display pins registered, 1 cycle after counter/latch change.
// Backpressure: waits on converter done; abandons a request after TIMEOUT cycles.
module seg7_bcd_scan
    import seg7_bcd_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 5000000,
    parameter int SCAN_DIV    = 100000,
    parameter int BLANK_CYC   = 1000,
    parameter int TIMEOUT     = 1024,
    parameter int DP_POS      = 3
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    seg7_bcd_scan_if.master         cnv,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [3:0]              an,
    output logic                    disp_valid,
    output logic                    conv_err
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1)    ? $clog2(SCAN_DIV)    : 1;
    localparam int TW = (TIMEOUT > 1)     ? $clog2(TIMEOUT)     : 1;

    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_LIM = SW'(BLANK_CYC);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [2:0]    DP_SEL    = 3'(DP_POS);
    localparam bit            DP_ON     = (DP_POS < 4);

    conv_state_e   state_q, state_d;
    logic [RW-1:0] ref_q, ref_d;
    logic [TW-1:0] tmo_q, tmo_d;
    bcd_word_t     latch_q, latch_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          start_q, start_d;

    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    dig_q, dig_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;

    logic [3:0]    nib_zero, zero_hi;
    logic [3:0]    dec_nib;
    logic          dec_blank;
    logic [6:0]    dec_seg;

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        tmo_d   = tmo_q;
        latch_d = latch_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        case (state_q)
            C_IDLE: begin
                if (ref_q == REF_LAST) begin
                    ref_d   = '0;
                    tmo_d   = '0;
                    state_d = C_REQ;
                end else begin
                    ref_d = ref_q + 1'b1;
                end
            end
            C_REQ, C_WAIT: begin
                // A single timer covers acceptance and completion together
                if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = C_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (state_q == C_REQ && !cnv.bcd_done) begin
                        state_d = C_WAIT;
                    end else if (state_q == C_WAIT && cnv.bcd_done) begin
                        state_d = C_LATCH;
                    end
                end
            end
            C_LATCH: begin
                latch_d = cnv.bcd_din;
                valid_d = 1'b1;
                state_d = C_IDLE;
            end
            default: state_d = C_IDLE;
        endcase
        start_d = (state_d != C_IDLE);
    end

    assign nib_zero = {latch_q[15:12] == 4'd0, latch_q[11:8] == 4'd0,
                       latch_q[7:4]   == 4'd0, latch_q[3:0]  == 4'd0};
    assign zero_hi  = {nib_zero[3], &nib_zero[3:2], &nib_zero[3:1], &nib_zero[3:0]};

    always_comb begin
        slot_d    = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        dig_d     = (slot_q == SLOT_LAST) ? dig_q + 1'b1 : dig_q;
        dec_nib   = valid_q ? latch_q[{dig_q, 2'b00} +: 4] : 4'hF;
        // Zeros at or below the decimal point stay lit so "0.05" keeps its leading 0
        dec_blank = valid_q && (dig_q != 2'd0) && zero_hi[dig_q]
                    && !(DP_ON && ({1'b0, dig_q} <= DP_SEL));
        an_d      = 4'hF;
        seg_d     = SEG_OFF;
        dp_d      = 1'b1;
        if (slot_q >= BLANK_LIM) begin
            an_d  = anode_sel(dig_q);
            seg_d = dec_seg;
            dp_d  = !(valid_q && DP_ON && ({1'b0, dig_q} == DP_SEL));
        end
    end

    seg7_decode u_dec (
        .nib_i   (dec_nib),
        .blank_i (dec_blank),
        .seg_o   (dec_seg)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= C_IDLE;
            ref_q   <= '0;
            tmo_q   <= '0;
            latch_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            slot_q  <= '0;
            dig_q   <= 2'd0;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
            an_q    <= 4'hF;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            tmo_q   <= tmo_d;
            latch_q <= latch_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            start_q <= start_d;
            slot_q  <= slot_d;
            dig_q   <= dig_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign cnv.bcd_start = start_q;
    assign seg           = seg_q;
    assign dp            = dp_q;
    assign an            = an_q;
    assign disp_valid    = valid_q;
    assign conv_err      = err_q;

endmodule

// File: tb/tb_seg7_bcd_scan.sv
// Directed bench for seg7_bcd_scan: two instances (no decimal point / DP on digit 2) share one converter model.
module tb_seg7_bcd_scan;

    logic CLK;
    logic RSTN;
    int   checks = 0;
    int   errors = 0;
    int   cyc;
    bit   stuck;

    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [3:0] an_a, an_b;
    logic       valid_a, valid_b;
    logic       err_a, err_b;

    seg7_bcd_scan_if ifa ();
    seg7_bcd_scan_if ifb ();

    seg7_bcd_scan #(.REFRESH_DIV(20), .SCAN_DIV(16), .BLANK_CYC(2), .TIMEOUT(30), .DP_POS(4)) dut_a (
        .CLK(CLK), .RSTN(RSTN), .cnv(ifa), .seg(seg_a), .dp(dp_a), .an(an_a),
        .disp_valid(valid_a), .conv_err(err_a)
    );

    seg7_bcd_scan #(.REFRESH_DIV(20), .SCAN_DIV(16), .BLANK_CYC(2), .TIMEOUT(30), .DP_POS(2)) dut_b (
        .CLK(CLK), .RSTN(RSTN), .cnv(ifb), .seg(seg_b), .dp(dp_b), .an(an_b),
        .disp_valid(valid_b), .conv_err(err_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Rising edges seen since the last reset release
    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Converter: done drops one cycle after start rises, returns 10 cycles later
    initial begin
        int   ph;
        int   k;
        logic prev;
        ph = 0; k = 0; prev = 1'b0;
        ifa.bcd_done = 1'b1;
        ifb.bcd_done = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            if (!RSTN) begin
                ph = 0;
                ifa.bcd_done = 1'b1;
                ifb.bcd_done = 1'b1;
            end else if (ph == 1) begin
                ifa.bcd_done = 1'b0;
                ifb.bcd_done = 1'b0;
                k  = 0;
                ph = 2;
            end else if (ph == 2) begin
                k++;
                if (k == 10) begin
                    ifa.bcd_done = 1'b1;
                    ifb.bcd_done = 1'b1;
                    ph = 0;
                end
            end else if (ifa.bcd_start && !prev && !stuck) begin
                ph = 1;
            end
            prev = RSTN ? ifa.bcd_start : 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected pins after rising edge n: slot (n-1)%16 of digit ((n-1)/16)%4
    task automatic chk_scan(input string tag, input int n, input logic [27:0] exp_seg, input int dpd,
                            input logic [3:0] an_o, input logic [6:0] seg_o, input logic dp_o);
        int         s, d;
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        s = (n - 1) % 16;
        d = ((n - 1) / 16) % 4;
        if (s < 2) begin
            ea = 4'hF; es = 7'h7F; ed = 1'b1;
        end else begin
            ea    = 4'hF;
            ea[d] = 1'b0;
            es    = exp_seg[d*7 +: 7];
            ed    = (d == dpd) ? 1'b0 : 1'b1;
        end
        chk({tag, "_an"},  32'(an_o),  32'(ea));
        chk({tag, "_seg"}, 32'(seg_o), 32'(es));
        chk({tag, "_dp"},  32'(dp_o),  32'(ed));
    endtask

    localparam logic [27:0] ALL_DASH = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
    localparam logic [27:0] A_0512   = {7'h7F, 7'h12, 7'h79, 7'h24};
    localparam logic [27:0] B_0000   = {7'h7F, 7'h40, 7'h40, 7'h40};
    localparam logic [27:0] A_00A5   = {7'h7F, 7'h7F, 7'h3F, 7'h12};

    initial begin
        RSTN          = 1'b0;
        stuck         = 1'b1;
        ifa.bcd_din   = 16'h0512;
        ifb.bcd_din   = 16'h0000;
        repeat (3) @(negedge CLK);
        chk("rst_start", 32'(ifa.bcd_start), 32'd0);
        chk("rst_seg",   32'(seg_a),   32'h7F);
        chk("rst_dp",    32'(dp_a),    32'd1);
        chk("rst_an",    32'(an_a),    32'hF);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_err",   32'(err_a),   32'd0);
        RSTN = 1'b1;

        // First request times out, then 16'h0512 is latched, then a second timeout
        for (int n = 1; n <= 156; n++) begin
            @(negedge CLK);
            if (n <= 83) begin
                chk_scan("a_dash", n, ALL_DASH, 4, an_a, seg_a, dp_a);
                chk_scan("b_dash", n, ALL_DASH, 4, an_b, seg_b, dp_b);
            end else begin
                chk_scan("a_0512", n, A_0512, 4, an_a, seg_a, dp_a);
                chk_scan("b_0000", n, B_0000, 2, an_b, seg_b, dp_b);
            end
            case (n)
                19:  chk("req1_pre",  32'(ifa.bcd_start), 32'd0);
                20:  chk("req1_rise", 32'(ifa.bcd_start), 32'd1);
                49:  begin
                         chk("tmo1_hold", 32'(ifa.bcd_start), 32'd1);
                         chk("tmo1_noerr", 32'(err_a), 32'd0);
                     end
                50:  begin
                         chk("tmo1_drop", 32'(ifa.bcd_start), 32'd0);
                         chk("tmo1_err",  32'(err_a), 32'd1);
                     end
                51:  begin
                         chk("tmo1_errend", 32'(err_a), 32'd0);
                         chk("tmo1_valid",  32'(valid_a), 32'd0);
                     end
                69:  begin
                         chk("req2_pre", 32'(ifa.bcd_start), 32'd0);
                         stuck = 1'b0;
                     end
                70:  chk("req2_rise", 32'(ifa.bcd_start), 32'd1);
                82:  begin
                         chk("latch_start", 32'(ifa.bcd_start), 32'd1);
                         chk("latch_pre",   32'(valid_a), 32'd0);
                     end
                83:  begin
                         chk("latch_drop",  32'(ifa.bcd_start), 32'd0);
                         chk("latch_valid", 32'(valid_a), 32'd1);
                         chk("latch_validb", 32'(valid_b), 32'd1);
                     end
                84:  stuck = 1'b1;
                102: chk("req3_pre",  32'(ifa.bcd_start), 32'd0);
                103: chk("req3_rise", 32'(ifa.bcd_start), 32'd1);
                132: chk("tmo2_hold", 32'(ifa.bcd_start), 32'd1);
                133: begin
                         chk("tmo2_drop",  32'(ifa.bcd_start), 32'd0);
                         chk("tmo2_err",   32'(err_a), 32'd1);
                         chk("tmo2_valid", 32'(valid_a), 32'd1);
                     end
                134: chk("tmo2_errend", 32'(err_a), 32'd0);
                152: begin
                         chk("req4_pre", 32'(ifa.bcd_start), 32'd0);
                         stuck = 1'b0;
                     end
                153: chk("req4_rise", 32'(ifa.bcd_start), 32'd1);
                default: ;
            endcase
        end

        // Converter is busy (C_WAIT); reset must clear everything at once
        RSTN = 1'b0;
        #1;
        chk("arst_start", 32'(ifa.bcd_start), 32'd0);
        chk("arst_an",    32'(an_a),    32'hF);
        chk("arst_seg",   32'(seg_a),   32'h7F);
        chk("arst_valid", 32'(valid_a), 32'd0);
        ifa.bcd_din = 16'h00A5;
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;

        for (int n = 1; n <= 98; n++) begin
            @(negedge CLK);
            if (n <= 33) begin
                chk_scan("a_dash2", n, ALL_DASH, 4, an_a, seg_a, dp_a);
                chk_scan("b_dash2", n, ALL_DASH, 4, an_b, seg_b, dp_b);
            end else begin
                chk_scan("a_00a5",  n, A_00A5, 4, an_a, seg_a, dp_a);
                chk_scan("b_0000b", n, B_0000, 2, an_b, seg_b, dp_b);
            end
            case (n)
                19: chk("post_rst_pre",  32'(ifa.bcd_start), 32'd0);
                20: chk("post_rst_rise", 32'(ifa.bcd_start), 32'd1);
                33: chk("post_rst_valid", 32'(valid_a), 32'd1);
                default: ;
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
